// File: rtl/xc20xx_lut_cfg_loader_pkg.sv
// Shared definitions for the LUT4 INIT configuration loader: state encoding,
// stream framing patterns and field widths.
package xc20xx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LENGTH = 3'd1,
    ST_POST   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_STOP   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } cfg_state_e;

  localparam logic [3:0] PREAMBLE     = 4'b0010;
  localparam logic [3:0] POSTAMBLE    = 4'b1111;
  localparam int         LEN_W        = 24;
  localparam int         FRAME_DATA_W = 16;
  localparam int         STOP_BITS    = 3;

endpackage

// File: rtl/xc20xx_lut_cfg_loader_if.sv
// Serial stream input and INIT-write output bundle of the LUT4 config loader.
interface xc20xx_lut_cfg_loader_if #(parameter int ADDR_W = 6);

  logic              DIN;
  logic              DIN_VALID;
  logic              CFG_WE;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic [15:0]       CFG_DATA;
  logic              BUSY;
  logic              DONE;
  logic              ERROR;

  // master: the loader itself; slave: the stream source / LUT store side
  modport master (
    input  DIN, DIN_VALID,
    output CFG_WE, CFG_ADDR, CFG_DATA, BUSY, DONE, ERROR
  );

  modport slave (
    output DIN, DIN_VALID,
    input  CFG_WE, CFG_ADDR, CFG_DATA, BUSY, DONE, ERROR
  );

endinterface

// File: rtl/xc20xx_lut_cfg_loader_shift.sv
// Width-parameterised MSB-first shift register with enable and clear.
// Clear wins over enable and loads all zeros.
module xc20xx_cfg_shift #(
  parameter int             W       = 16,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr)
      sh_d = '0;
    else if (en)
      sh_d = {sh_q[W-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sh_q <= RST_VAL;
    else
      sh_q <= sh_d;
  end

  assign q = sh_q;

endmodule

// File: rtl/xc20xx_lut_cfg_loader.sv
// Bit-serial configuration loader: parses preamble, length, postamble and
// framed INIT words, issuing one 16-bit INIT write per LUT.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | hunting for preamble 0010 in the idle-ones stream
//   ST_LENGTH | shifting in the 24-bit LUT count L
//   ST_POST   | checking the four postamble ones
//   ST_START  | waiting for a frame start bit (0); finishes when index == L
//   ST_DATA   | shifting in 16 INIT bits, MSB first
//   ST_STOP   | checking three stop ones, then issuing the write
//   ST_DONE   | all frames written, input ignored until reset
//   ST_ERR    | framing or length fault, input ignored until reset
module xc20xx_lut_cfg_loader
  import xc20xx_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 64,
  parameter int ADDR_W   = 6
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  xc20xx_lut_cfg_loader_if.master cfg
);

  cfg_state_e                state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [ADDR_W:0]           idx_q, idx_d;
  logic                      we_q, we_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [FRAME_DATA_W-1:0]   data_q, data_d;

  logic                      hdr_en, hdr_clr, dat_en;
  logic [LEN_W-1:0]          hdr;
  logic [LEN_W-1:0]          hdr_next;
  logic [FRAME_DATA_W-1:0]   frame;

  // The header shifter doubles as the preamble window (low 4 bits) and L.
  xc20xx_cfg_shift #(.W(LEN_W), .RST_VAL({LEN_W{1'b1}})) u_hdr (
    .clk(CLK), .rst_n(RESET_N), .clr(hdr_clr), .en(hdr_en), .din(cfg.DIN), .q(hdr)
  );

  xc20xx_cfg_shift #(.W(FRAME_DATA_W), .RST_VAL('0)) u_data (
    .clk(CLK), .rst_n(RESET_N), .clr(1'b0), .en(dat_en), .din(cfg.DIN), .q(frame)
  );

  assign hdr_next = {hdr[LEN_W-2:0], cfg.DIN};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hdr_en  = 1'b0;
    hdr_clr = 1'b0;
    dat_en  = 1'b0;
    case (state_q)
      ST_IDLE: if (cfg.DIN_VALID) begin
        hdr_en = 1'b1;
        if (hdr_next[3:0] == PREAMBLE) begin
          hdr_clr = 1'b1;
          state_d = ST_LENGTH;
          cnt_d   = 5'(LEN_W - 1);
        end
      end
      ST_LENGTH: if (cfg.DIN_VALID) begin
        hdr_en = 1'b1;
        if (cnt_q == 5'd0) begin
          // full-width compare so oversize counts cannot alias into range
          if (hdr_next > LEN_W'(NUM_LUTS)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_POST;
            cnt_d   = 5'($bits(POSTAMBLE) - 1);
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_POST: if (cfg.DIN_VALID) begin
        if (cfg.DIN != POSTAMBLE[cnt_q[1:0]])
          state_d = ST_ERR;
        else if (cnt_q == 5'd0)
          state_d = (hdr == '0) ? ST_DONE : ST_START;
        else
          cnt_d = cnt_q - 5'd1;
      end
      ST_START: begin
        // index reaching L is checked here so DONE trails the last strobe
        if (LEN_W'(idx_q) == hdr) begin
          state_d = ST_DONE;
        end else if (cfg.DIN_VALID && !cfg.DIN) begin
          state_d = ST_DATA;
          cnt_d   = 5'(FRAME_DATA_W - 1);
        end
      end
      ST_DATA: if (cfg.DIN_VALID) begin
        dat_en = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = ST_STOP;
          cnt_d   = 5'(STOP_BITS - 1);
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_STOP: if (cfg.DIN_VALID) begin
        if (!cfg.DIN) begin
          state_d = ST_ERR;
        end else if (cnt_q == 5'd0) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          data_d  = frame;
          idx_d   = idx_q + 1'b1;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign cfg.CFG_WE   = we_q;
  assign cfg.CFG_ADDR = addr_q;
  assign cfg.CFG_DATA = data_q;
  assign cfg.BUSY     = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign cfg.DONE     = (state_q == ST_DONE);
  assign cfg.ERROR    = (state_q == ST_ERR);

endmodule
